// File: rtl/byte_lane_sequencer_pkg.sv
// Shared types and defaults for the byte-lane capture sequencer.
// Lane count and width defaults match the 7 x 8-bit TT pin capture register.
package byte_lane_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_DRAIN
    } state_e;

    localparam int LANES_DEF  = 7;
    localparam int W_DEF      = 8;
    localparam int LANE_IDX_W = $clog2(LANES_DEF);

endpackage

// File: rtl/byte_lane_sequencer_lane_buffer.sv
// LANES x W lane register array with per-lane and broadcast write.
// Read is a plain mux on the requested lane index.
module lane_buffer
    import byte_lane_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int W     = W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we_i,
    input  logic                     bcast_i,
    input  logic [$clog2(LANES)-1:0] widx_i,
    input  logic [W-1:0]             wdata_i,
    input  logic [$clog2(LANES)-1:0] ridx_i,
    output logic [W-1:0]             rdata_o
);

    logic [W-1:0] lanes_q [LANES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) begin
                lanes_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (bcast_i || (we_i && (int'(widx_i) == i))) begin
                    lanes_q[i] <= wdata_i;
                end
            end
        end
    end

    assign rdata_o = lanes_q[ridx_i];

endmodule

// File: rtl/byte_lane_sequencer.sv
// Fill-then-drain byte sequencer for the lane capture buffer.
// Input and output sides are never open at the same time.
module byte_lane_sequencer
    import byte_lane_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int W     = W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             in_data,
    input  logic                     mode_rep,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             out_data,
    output logic [$clog2(LANES)-1:0] lane_idx,
    output logic                     frame_done
);

    localparam int IW = $clog2(LANES);
    localparam logic [IW-1:0] LAST = IW'(LANES - 1);

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          we, bcast;
    logic [W-1:0]  rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        we         = 1'b0;
        bcast      = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // held low while reset is asserted
                in_ready = rst_n;
                if (in_valid && rst_n) begin
                    if (mode_rep) begin
                        bcast   = 1'b1;
                        state_d = ST_DRAIN;
                    end else begin
                        we      = 1'b1;
                        idx_d   = IW'(1);
                        state_d = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                in_ready = rst_n;
                if (in_valid && rst_n) begin
                    we = 1'b1;
                    if (idx_q == LAST) begin
                        idx_d   = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (idx_q == LAST) begin
                        frame_done = 1'b1;
                        idx_d      = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    lane_buffer #(
        .LANES (LANES),
        .W     (W)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (we),
        .bcast_i (bcast),
        .widx_i  (idx_q),
        .wdata_i (in_data),
        .ridx_i  (idx_q),
        .rdata_o (rdata)
    );

    assign out_data = out_valid ? rdata : '0;
    assign lane_idx = idx_q;

endmodule

// File: tb/tb_byte_lane_sequencer.sv
// Randomized bench for byte_lane_sequencer against a frame-level model.
// Model tracks captured bytes and a queue of bytes still owed downstream.
module tb_byte_lane_sequencer;

    localparam int LANES = 7;
    localparam int W     = 8;
    localparam int IW    = $clog2(LANES);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          mode_rep = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic [IW-1:0] lane_idx;
    logic          frame_done;

    int vectors = 0;
    int errors  = 0;
    int frames  = 0;

    logic [W-1:0] mbuf [LANES];
    int           filled;
    logic [W-1:0] pend [$];

    byte_lane_sequencer #(
        .LANES (LANES),
        .W     (W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .mode_rep   (mode_rep),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .lane_idx   (lane_idx),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        filled = 0;
        pend.delete();
        for (int i = 0; i < LANES; i++) mbuf[i] = '0;
    endtask

    task automatic check_reset_outputs();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_lane_idx", 32'(lane_idx), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
    endtask

    // Called at a negedge: drive, compare, advance model, move to next negedge.
    task automatic step(bit iv, logic [W-1:0] id, bit mr, bit ordy);
        bit          exp_ir;
        bit          exp_ov;
        logic [W-1:0] exp_od;
        int          exp_idx;
        bit          exp_fd;
        in_valid  = iv;
        in_data   = id;
        mode_rep  = mr;
        out_ready = ordy;
        #1;
        exp_ir  = (pend.size() == 0);
        exp_ov  = (pend.size() != 0);
        exp_od  = exp_ov ? pend[0] : '0;
        exp_idx = exp_ov ? (LANES - pend.size()) : filled;
        exp_fd  = exp_ov && ordy && (pend.size() == 1);
        check("in_ready", 32'(in_ready), 32'(exp_ir));
        check("out_valid", 32'(out_valid), 32'(exp_ov));
        check("out_data", 32'(out_data), 32'(exp_od));
        check("lane_idx", 32'(lane_idx), 32'(exp_idx));
        check("frame_done", 32'(frame_done), 32'(exp_fd));
        if (exp_ov && ordy) begin
            void'(pend.pop_front());
            if (pend.size() == 0) frames++;
        end else if (exp_ir && iv) begin
            if (filled == 0 && mr) begin
                for (int i = 0; i < LANES; i++) begin
                    mbuf[i] = id;
                    pend.push_back(id);
                end
            end else begin
                mbuf[filled] = id;
                filled++;
                if (filled == LANES) begin
                    for (int i = 0; i < LANES; i++) pend.push_back(mbuf[i]);
                    filled = 0;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // load mode 0x11..0x77, drain with out_ready held high
        for (int i = 1; i <= LANES; i++) step(1'b1, 8'(i * 8'h11), 1'b0, 1'b1);
        for (int i = 0; i < LANES; i++) step(1'b0, 8'h00, 1'b0, 1'b1);

        // replicate 0xA5, in_valid with 0xFF held during drain
        step(1'b1, 8'hA5, 1'b1, 1'b0);
        for (int i = 0; i < LANES; i++) step(1'b1, 8'hFF, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // fill stall then backpressure 1,0,0,1,...
        for (int i = 0; i < 2 * LANES; i++) step(i[0], 8'(8'hC0 + i), 1'b0, 1'b0);
        for (int i = 0; i < 3 * LANES; i++) step(1'b1, 8'hFF, 1'b0, (i % 3) == 0);

        // reset asserted mid-drain
        step(1'b1, 8'h3C, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 3) != 0,
                 8'($urandom),
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) == 1);
        end

        check("frames_seen_min", 32'(frames >= 20), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
